// File: rtl/dram_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : dram_cmd_issuer
// Description : Timing-enforcing DRAM command issue stage. Holds one command
//               from the scheduler until bank/bus timing allows it, drives the
//               DRAM command bus, serializes write data into bus beats and
//               reassembles read beats into tagged 64-bit responses.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_cmd_issuer #(
  parameter int BUS_WIDTH          = 16,
  parameter int BANK_GROUPS        = 8,
  parameter int BANKS_PER_GROUP    = 8,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int RD_TAGS            = 4
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]                      bank_group_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0]                  bank_in,
  input  logic [ROW_BITS-1:0]                                 row_in,
  input  logic [COL_BITS-1:0]                                 col_in,
  input  logic [63:0]                                         val_in,
  input  logic [2:0]                                          cmd_in,
  input  logic                                                valid_in,
  output logic                                                cmd_ready,
  output logic [2:0]                                          dram_cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]                      dram_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0]                  dram_bank_out,
  output logic [((ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS)-1:0] dram_addr_out,
  output logic                                                dram_cmd_valid_out,
  output logic [BUS_WIDTH-1:0]                                dram_wdata_out,
  output logic                                                dram_wdata_valid_out,
  input  logic [BUS_WIDTH-1:0]                                dram_rdata_in,
  input  logic                                                dram_rdata_valid_in,
  output logic [63:0]                                         rd_val_out,
  output logic [$clog2(BANK_GROUPS)-1:0]                      rd_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0]                  rd_bank_out,
  output logic [COL_BITS-1:0]                                 rd_col_out,
  output logic                                                rd_valid_out,
  output logic                                                error_out
);

  localparam int BG_W       = $clog2(BANK_GROUPS);
  localparam int BK_W       = $clog2(BANKS_PER_GROUP);
  localparam int BANK_W     = BG_W + BK_W;
  localparam int BANK_SLOTS = 1 << BANK_W;
  localparam int ADDR_W     = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int BEATS      = 64 / BUS_WIDTH;
  localparam int MAX_LAT_AP = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int MAX_LAT    = (MAX_LAT_AP > BEATS) ? MAX_LAT_AP : BEATS;
  localparam int CNT_W      = $clog2(MAX_LAT + 1);
  localparam int TAG_W      = BG_W + BK_W + COL_BITS;
  localparam int PTR_W      = (RD_TAGS > 1) ? $clog2(RD_TAGS) : 1;
  localparam int OCC_W      = $clog2(RD_TAGS + 1);
  localparam int BEAT_W     = $clog2(BEATS + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  // Counters hold the number of blocked cycles remaining after the issue
  // cycle, so a bank is usable again exactly LATENCY cycles after issue.
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ACT_LOAD  = CNT_W'((ACTIVATION_LATENCY > 0) ? ACTIVATION_LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0]  PRE_LOAD  = CNT_W'((PRECHARGE_LATENCY > 0) ? PRECHARGE_LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0]  COL_LOAD  = CNT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEATS_N   = BEAT_W'(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [OCC_W-1:0]  TAGS_FULL = OCC_W'(RD_TAGS);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RD_TAGS - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // Holding register
  logic                hold_valid_q, hold_valid_d;
  logic [2:0]          hold_cmd_q, hold_cmd_d;
  logic [BG_W-1:0]     hold_bg_q, hold_bg_d;
  logic [BK_W-1:0]     hold_bank_q, hold_bank_d;
  logic [ROW_BITS-1:0] hold_row_q, hold_row_d;
  logic [COL_BITS-1:0] hold_col_q, hold_col_d;
  logic [63:0]         hold_val_q, hold_val_d;

  // Per-bank state and shared column-bus spacing counter
  logic                bank_open_q [BANK_SLOTS];
  logic                bank_open_d [BANK_SLOTS];
  logic [ROW_BITS-1:0] bank_row_q  [BANK_SLOTS];
  logic [ROW_BITS-1:0] bank_row_d  [BANK_SLOTS];
  logic [CNT_W-1:0]    bank_busy_q [BANK_SLOTS];
  logic [CNT_W-1:0]    bank_busy_d [BANK_SLOTS];
  logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;

  // Outstanding-read tag FIFO
  logic [TAG_W-1:0]    tag_mem_q [RD_TAGS];
  logic [TAG_W-1:0]    tag_mem_d [RD_TAGS];
  logic [PTR_W-1:0]    tag_wr_ptr_q, tag_wr_ptr_d;
  logic [PTR_W-1:0]    tag_rd_ptr_q, tag_rd_ptr_d;
  logic [OCC_W-1:0]    tag_cnt_q, tag_cnt_d;

  // Write serializer and read assembler
  logic [63:0]         wr_sh_q, wr_sh_d;
  logic [BEAT_W-1:0]   wr_left_q, wr_left_d;
  logic [63:0]         rd_sh_q, rd_sh_d;
  logic [BEAT_W-1:0]   rd_beats_q, rd_beats_d;

  // Registered outputs
  logic [2:0]          dram_cmd_q, dram_cmd_d;
  logic [BG_W-1:0]     dram_bg_q, dram_bg_d;
  logic [BK_W-1:0]     dram_bank_q, dram_bank_d;
  logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
  logic                dram_cmd_valid_q, dram_cmd_valid_d;
  logic [BUS_WIDTH-1:0] dram_wdata_q, dram_wdata_d;
  logic                dram_wdata_valid_q, dram_wdata_valid_d;
  logic [63:0]         rd_val_q, rd_val_d;
  logic [BG_W-1:0]     rd_bg_q, rd_bg_d;
  logic [BK_W-1:0]     rd_bank_q, rd_bank_d;
  logic [COL_BITS-1:0] rd_col_q, rd_col_d;
  logic                rd_valid_q, rd_valid_d;
  logic                error_q, error_d;

  // Issue decision terms
  logic [BANK_W-1:0]   hold_idx;
  logic                bank_ready, col_free, row_hit;
  logic                tag_full, tag_empty, beat_ok, tag_pop, tag_push;
  logic                timing_ok, legal, issue_now, drop_now, hold_done, accept;
  logic [63:0]         rd_shifted;
  logic [TAG_W-1:0]    tag_head;

  assign hold_idx   = {hold_bg_q, hold_bank_q};
  assign bank_ready = (bank_busy_q[hold_idx] == '0);
  assign col_free   = (col_cnt_q == '0);
  assign row_hit    = bank_open_q[hold_idx] && (bank_row_q[hold_idx] == hold_row_q);
  assign tag_full   = (tag_cnt_q == TAGS_FULL);
  assign tag_empty  = (tag_cnt_q == '0);
  assign beat_ok    = dram_rdata_valid_in && !tag_empty;
  assign tag_pop    = beat_ok && (rd_beats_q == LAST_BEAT);
  assign tag_head   = tag_mem_q[tag_rd_ptr_q];
  assign rd_shifted = (rd_sh_q >> BUS_WIDTH) | (64'(dram_rdata_in) << (64 - BUS_WIDTH));

  // Timing gate and legality of the held command; illegal commands wait for
  // the same gate so they are judged at the moment they would have issued.
  always_comb begin
    timing_ok = 1'b0;
    legal     = 1'b0;
    case (hold_cmd_q)
      CMD_ACT: begin timing_ok = bank_ready; legal = !bank_open_q[hold_idx]; end
      CMD_PRE: begin timing_ok = bank_ready; legal = 1'b1; end
      CMD_RD:  begin timing_ok = bank_ready && col_free && (!tag_full || tag_pop); legal = row_hit; end
      CMD_WR:  begin timing_ok = bank_ready && col_free; legal = row_hit; end
      default: begin timing_ok = 1'b1; legal = 1'b0; end
    endcase
  end

  assign issue_now = hold_valid_q && timing_ok && legal;
  assign drop_now  = hold_valid_q && timing_ok && !legal;
  assign hold_done = issue_now || drop_now;
  assign cmd_ready = !hold_valid_q || hold_done;
  assign accept    = valid_in && cmd_ready && (cmd_in != CMD_NOP);
  assign tag_push  = issue_now && (hold_cmd_q == CMD_RD);

  // Next-state computation for every register in the block
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    hold_bg_d    = hold_bg_q;
    hold_bank_d  = hold_bank_q;
    hold_row_d   = hold_row_q;
    hold_col_d   = hold_col_q;
    hold_val_d   = hold_val_q;
    bank_open_d  = bank_open_q;
    bank_row_d   = bank_row_q;
    bank_busy_d  = bank_busy_q;
    col_cnt_d    = (col_cnt_q != '0) ? col_cnt_q - CNT_ONE : '0;
    tag_mem_d    = tag_mem_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q;
    wr_sh_d      = wr_sh_q;
    wr_left_d    = wr_left_q;
    rd_sh_d      = rd_sh_q;
    rd_beats_d   = rd_beats_q;
    dram_cmd_d         = CMD_NOP;
    dram_bg_d          = '0;
    dram_bank_d        = '0;
    dram_addr_d        = '0;
    dram_cmd_valid_d   = 1'b0;
    dram_wdata_d       = '0;
    dram_wdata_valid_d = 1'b0;
    rd_val_d           = '0;
    rd_bg_d            = '0;
    rd_bank_d          = '0;
    rd_col_d           = '0;
    rd_valid_d         = 1'b0;
    error_d            = drop_now || (dram_rdata_valid_in && tag_empty);

    for (int i = 0; i < BANK_SLOTS; i++) begin
      if (bank_busy_q[i] != '0) bank_busy_d[i] = bank_busy_q[i] - CNT_ONE;
    end

    // Emit the next write beat before a new burst may reload the shifter
    if (wr_left_q != '0) begin
      dram_wdata_d       = wr_sh_q[BUS_WIDTH-1:0];
      dram_wdata_valid_d = 1'b1;
      wr_sh_d            = wr_sh_q >> BUS_WIDTH;
      wr_left_d          = wr_left_q - BEAT_ONE;
    end

    if (issue_now) begin
      dram_cmd_valid_d = 1'b1;
      dram_cmd_d       = hold_cmd_q;
      dram_bg_d        = hold_bg_q;
      dram_bank_d      = hold_bank_q;
      case (hold_cmd_q)
        CMD_ACT: begin
          bank_open_d[hold_idx] = 1'b1;
          bank_row_d[hold_idx]  = hold_row_q;
          bank_busy_d[hold_idx] = ACT_LOAD;
          dram_addr_d           = ADDR_W'(hold_row_q);
        end
        CMD_PRE: begin
          bank_open_d[hold_idx] = 1'b0;
          bank_busy_d[hold_idx] = PRE_LOAD;
        end
        CMD_RD: begin
          col_cnt_d                = COL_LOAD;
          dram_addr_d              = ADDR_W'(hold_col_q);
          tag_mem_d[tag_wr_ptr_q]  = {hold_bg_q, hold_bank_q, hold_col_q};
          tag_wr_ptr_d             = (tag_wr_ptr_q == PTR_LAST) ? '0 : tag_wr_ptr_q + PTR_ONE;
        end
        CMD_WR: begin
          col_cnt_d   = COL_LOAD;
          dram_addr_d = ADDR_W'(hold_col_q);
          wr_sh_d     = hold_val_q;
          wr_left_d   = BEATS_N;
        end
        default: ;
      endcase
    end

    // Read beats are accepted only while a tag is outstanding
    if (beat_ok) begin
      if (tag_pop) begin
        rd_valid_d   = 1'b1;
        rd_val_d     = rd_shifted;
        rd_col_d     = tag_head[COL_BITS-1:0];
        rd_bank_d    = tag_head[COL_BITS +: BK_W];
        rd_bg_d      = tag_head[COL_BITS+BK_W +: BG_W];
        rd_sh_d      = '0;
        rd_beats_d   = '0;
        tag_rd_ptr_d = (tag_rd_ptr_q == PTR_LAST) ? '0 : tag_rd_ptr_q + PTR_ONE;
      end else begin
        rd_sh_d    = rd_shifted;
        rd_beats_d = rd_beats_q + BEAT_ONE;
      end
    end

    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + OCC_ONE;
      2'b01:   tag_cnt_d = tag_cnt_q - OCC_ONE;
      default: tag_cnt_d = tag_cnt_q;
    endcase

    if (hold_done) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = cmd_in;
      hold_bg_d    = bank_group_in;
      hold_bank_d  = bank_in;
      hold_row_d   = row_in;
      hold_col_d   = col_in;
      hold_val_d   = val_in;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_valid_q <= 1'b0;
      hold_cmd_q   <= CMD_NOP;
      hold_bg_q    <= '0;
      hold_bank_q  <= '0;
      hold_row_q   <= '0;
      hold_col_q   <= '0;
      hold_val_q   <= '0;
      for (int i = 0; i < BANK_SLOTS; i++) begin
        bank_open_q[i] <= 1'b0;
        bank_row_q[i]  <= '0;
        bank_busy_q[i] <= '0;
      end
      col_cnt_q <= '0;
      for (int i = 0; i < RD_TAGS; i++) tag_mem_q[i] <= '0;
      tag_wr_ptr_q       <= '0;
      tag_rd_ptr_q       <= '0;
      tag_cnt_q          <= '0;
      wr_sh_q            <= '0;
      wr_left_q          <= '0;
      rd_sh_q            <= '0;
      rd_beats_q         <= '0;
      dram_cmd_q         <= CMD_NOP;
      dram_bg_q          <= '0;
      dram_bank_q        <= '0;
      dram_addr_q        <= '0;
      dram_cmd_valid_q   <= 1'b0;
      dram_wdata_q       <= '0;
      dram_wdata_valid_q <= 1'b0;
      rd_val_q           <= '0;
      rd_bg_q            <= '0;
      rd_bank_q          <= '0;
      rd_col_q           <= '0;
      rd_valid_q         <= 1'b0;
      error_q            <= 1'b0;
    end else begin
      hold_valid_q       <= hold_valid_d;
      hold_cmd_q         <= hold_cmd_d;
      hold_bg_q          <= hold_bg_d;
      hold_bank_q        <= hold_bank_d;
      hold_row_q         <= hold_row_d;
      hold_col_q         <= hold_col_d;
      hold_val_q         <= hold_val_d;
      bank_open_q        <= bank_open_d;
      bank_row_q         <= bank_row_d;
      bank_busy_q        <= bank_busy_d;
      col_cnt_q          <= col_cnt_d;
      tag_mem_q          <= tag_mem_d;
      tag_wr_ptr_q       <= tag_wr_ptr_d;
      tag_rd_ptr_q       <= tag_rd_ptr_d;
      tag_cnt_q          <= tag_cnt_d;
      wr_sh_q            <= wr_sh_d;
      wr_left_q          <= wr_left_d;
      rd_sh_q            <= rd_sh_d;
      rd_beats_q         <= rd_beats_d;
      dram_cmd_q         <= dram_cmd_d;
      dram_bg_q          <= dram_bg_d;
      dram_bank_q        <= dram_bank_d;
      dram_addr_q        <= dram_addr_d;
      dram_cmd_valid_q   <= dram_cmd_valid_d;
      dram_wdata_q       <= dram_wdata_d;
      dram_wdata_valid_q <= dram_wdata_valid_d;
      rd_val_q           <= rd_val_d;
      rd_bg_q            <= rd_bg_d;
      rd_bank_q          <= rd_bank_d;
      rd_col_q           <= rd_col_d;
      rd_valid_q         <= rd_valid_d;
      error_q            <= error_d;
    end
  end

  assign dram_cmd_out         = dram_cmd_q;
  assign dram_bg_out          = dram_bg_q;
  assign dram_bank_out        = dram_bank_q;
  assign dram_addr_out        = dram_addr_q;
  assign dram_cmd_valid_out   = dram_cmd_valid_q;
  assign dram_wdata_out       = dram_wdata_q;
  assign dram_wdata_valid_out = dram_wdata_valid_q;
  assign rd_val_out           = rd_val_q;
  assign rd_bg_out            = rd_bg_q;
  assign rd_bank_out          = rd_bank_q;
  assign rd_col_out           = rd_col_q;
  assign rd_valid_out         = rd_valid_q;
  assign error_out            = error_q;

endmodule
`default_nettype wire
